// File: rtl/dp_pkg.sv
// Shared types and constants for the triple loader and its result FIFO.
package dp_pkg;

  localparam int DP_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    ISSUE  = 2'd3
  } dp_load_state_t;

endpackage

// File: rtl/dp_result_fifo.sv
// Result FIFO holding (z, x) pairs; the head is presented from a register so
// res_z/res_x leave the block with no read-mux path behind them.
module dp_result_fifo
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic signed [WIDTH-1:0] push_z,
  input  logic signed [WIDTH-1:0] push_x,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic signed [WIDTH-1:0] head_z,
  output logic signed [WIDTH-1:0] head_x
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic signed [WIDTH-1:0] head_z_q, head_z_d;
  logic signed [WIDTH-1:0] head_x_q, head_x_d;
  logic signed [WIDTH-1:0] mem_z [DEPTH];
  logic signed [WIDTH-1:0] mem_x [DEPTH];
  logic pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Next head is whatever sits at the new read pointer, bypassing the
    // array when that slot is being written this same cycle.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_z_d = push_z;
      head_x_d = push_x;
    end else begin
      head_z_d = mem_z[rd_ptr_d];
      head_x_d = mem_x[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr_q] <= push_z;
      mem_x[wr_ptr_q] <= push_x;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_z_q <= '0;
      head_x_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_z_q <= head_z_d;
      head_x_q <= head_x_d;
    end
  end

  assign count  = count_q;
  assign head_z = head_z_q;
  assign head_x = head_x_q;

endmodule

// File: rtl/dp_triple_loader.sv
// Operand sequencer and result collector around a fixed-latency datapath:
// loads a/b/c serially, issues when FIFO credit allows, collects z/x.
module dp_triple_loader
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] z,
  input  logic signed [WIDTH-1:0] x,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_z,
  output logic signed [WIDTH-1:0] res_x,
  output logic                    busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  dp_load_state_t state_q, state_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [CW-1:0]  fifo_count, inflight, occupancy;
  logic           hs, issue, credit_ok, push, pop;

  assign in_ready = (state_q != ISSUE);
  assign hs       = in_valid && in_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(vld_pipe_q[i]);
    end
    // Results already queued plus those still in the datapath must leave
    // room for this issue, so the FIFO can never be pushed while full.
    occupancy = fifo_count + inflight;
    credit_ok = (occupancy < CW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    issue   = 1'b0;
    unique case (state_q)
      LOAD_A: if (hs) begin a_d = in_data; state_d = LOAD_B; end
      LOAD_B: if (hs) begin b_d = in_data; state_d = LOAD_C; end
      LOAD_C: if (hs) begin c_d = in_data; state_d = ISSUE;  end
      ISSUE:  if (credit_ok) begin issue = 1'b1; state_d = LOAD_A; end
      default: state_d = LOAD_A;
    endcase
    vld_pipe_d = (vld_pipe_q << 1) | LAT'(issue);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Datapath output is only meaningful in the cycle its issue bit exits.
  assign push = vld_pipe_q[LAT-1];
  assign pop  = res_valid && res_ready;

  dp_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .push_z (z),
    .push_x (x),
    .pop    (pop),
    .count  (fifo_count),
    .head_z (res_z),
    .head_x (res_x)
  );

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign res_valid = (fifo_count != '0);
  assign busy      = (state_q != LOAD_A) || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_dp_triple_loader.sv
// Bench for dp_triple_loader: registered stub datapath (x=a+b, z=c-a), scoreboard
// queue filled as triples are sent and drained as results are popped.
module tb_dp_triple_loader;
  import dp_pkg::*;

  localparam int W     = DP_WIDTH;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, res_valid, res_ready, busy;
  logic signed [W-1:0] in_data, a, b, c, z, x, res_z, res_x;

  typedef struct {
    logic signed [W-1:0] z;
    logic signed [W-1:0] x;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_pop = -1;
  bit   chk_period = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dp_triple_loader #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a(a), .b(b), .c(c), .z(z), .x(x),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_x(res_x), .busy(busy)
  );

  // Stub datapath, one register stage.
  always @(posedge clk) begin
    x <= a + b;
    z <= c - a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexp_res", res_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_z", res_z, mon_e.z);
        chk("res_x", res_x, mon_e.x);
      end
      if (chk_period) begin
        if (last_pop >= 0) chk("period", cyc - last_pop, 4);
        last_pop = cyc;
      end
    end
  end

  task automatic send_word(input logic signed [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("hs_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic send_triple(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                             input logic signed [W-1:0] cv);
    res_t e;
    e.z = cv - av;
    e.x = av + bv;
    exp_q.push_back(e);
    send_word(av);
    send_word(bv);
    send_word(cv);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] av, bv, cv;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_z", res_z, 0);
    chk("rst_res_x", res_x, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_c", c, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Single triple, latency of result relative to the issue cycle.
    send_triple(5, 3, 7);
    @(negedge clk);
    chk("t1_issue_rdy", in_ready, 1'b0);
    chk("t1_v_n0", res_valid, 1'b0);
    @(negedge clk);
    chk("t1_v_n1", res_valid, 1'b0);
    @(negedge clk);
    chk("t1_v_n2", res_valid, 1'b1);
    @(negedge clk);
    chk("t1_v_n3", res_valid, 1'b0);
    wait_drain();

    // Negative operands.
    send_triple(-4, 9, -1);
    wait_drain();

    // Backpressure: fifth triple stalls in ISSUE with operands held.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      av = i * 7 - 11;
      bv = 100 + i;
      cv = -(i * 3) - 2;
      send_triple(av, bv, cv);
    end
    repeat (4) begin
      @(negedge clk);
      chk("t3_stall_rdy", in_ready, 1'b0);
      chk("t3_res_valid", res_valid, 1'b1);
      chk("t3_busy", busy, 1'b1);
      chk("t3_a", a, av);
      chk("t3_b", b, bv);
      chk("t3_c", c, cv);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("t3_issue_cyc", in_ready, 1'b0);
    @(negedge clk);
    chk("t3_resume", in_ready, 1'b1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_drain();

    // Back-to-back streaming, pointers wrap.
    chk_period = 1'b1;
    last_pop   = -1;
    for (int i = 0; i < 6; i++) begin
      send_triple(i * 1000 + 1, -i * 13, 2 * i - 5);
    end
    wait_drain();
    chk_period = 1'b0;

    // Gap between b and c.
    exp_q.push_back('{z: 40 - (-21), x: -21 + 17});
    send_word(-21);
    send_word(17);
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_rdy", in_ready, 1'b1);
      chk("t5_busy", busy, 1'b1);
      chk("t5_b_held", b, 17);
      @(posedge clk);
      #1;
    end
    send_word(40);
    wait_drain();

    // Reset mid-operation with results queued and one in flight.
    res_ready = 1'b0;
    send_triple(1, 2, 3);
    send_triple(4, 5, 6);
    send_triple(7, 8, 9);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_res_valid", res_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_res_z", res_z, 0);
    chk("t6_a", a, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    res_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6_no_stale", res_valid, 1'b0);
    chk("t6_idle", busy, 1'b0);
    @(posedge clk);
    #1;
    send_triple(-100, 50, 25);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
